// File: rtl/axi_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_bram_pkg
// Description : Shared FSM state encoding, AXI response codes and an
//               address-alignment helper for the AXI-Lite BRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_bram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ACC  = 3'd1,
        ST_RD_ACC  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RD_RESP = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Number of byte-offset bits inside one data word.
    function automatic int align_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_bram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_bram_ctrl_if
// Description : AXI4-Lite channel bundle (AW, W, B, AR, R) with master and
//               slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_bram_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
);
    logic [AXI_ADDR_WIDTH-1:0] AwAddr_DI;
    logic                      AwValid_SI;
    logic                      AwReady_SO;
    logic [DATA_WIDTH-1:0]     WData_DI;
    logic [DATA_WIDTH/8-1:0]   WStrb_DI;
    logic                      WValid_SI;
    logic                      WReady_SO;
    logic [1:0]                BResp_DO;
    logic                      BValid_SO;
    logic                      BReady_SI;
    logic [AXI_ADDR_WIDTH-1:0] ArAddr_DI;
    logic                      ArValid_SI;
    logic                      ArReady_SO;
    logic [DATA_WIDTH-1:0]     RData_DO;
    logic [1:0]                RResp_DO;
    logic                      RValid_SO;
    logic                      RReady_SI;

    modport master (
        output AwAddr_DI, AwValid_SI, WData_DI, WStrb_DI, WValid_SI,
        output BReady_SI, ArAddr_DI, ArValid_SI, RReady_SI,
        input  AwReady_SO, WReady_SO, BResp_DO, BValid_SO,
        input  ArReady_SO, RData_DO, RResp_DO, RValid_SO
    );

    modport slave (
        input  AwAddr_DI, AwValid_SI, WData_DI, WStrb_DI, WValid_SI,
        input  BReady_SI, ArAddr_DI, ArValid_SI, RReady_SI,
        output AwReady_SO, WReady_SO, BResp_DO, BValid_SO,
        output ArReady_SO, RData_DO, RResp_DO, RValid_SO
    );
endinterface
`default_nettype wire

// File: rtl/axi_bram_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : axi_bram_rr_arb
// Description : Two-way round-robin arbiter between the write and read
//               directions; priority starts on read and flips on every grant.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_bram_rr_arb (
    input  logic Clk_CI,
    input  logic Rst_RBI,
    input  logic i_wr_pend,
    input  logic i_rd_pend,
    input  logic i_take,
    output logic o_wr_gnt,
    output logic o_rd_gnt
);
    logic r_prio_wr;

    always_comb begin
        o_rd_gnt = i_rd_pend & (~i_wr_pend | ~r_prio_wr);
        o_wr_gnt = i_wr_pend & (~i_rd_pend |  r_prio_wr);
    end

    // The direction just served loses priority to the other one.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_prio_wr <= 1'b0;
        end else if (i_take) begin
            r_prio_wr <= o_rd_gnt;
        end
    end
endmodule
`default_nettype wire

// File: rtl/axi_lite_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_bram_ctrl
// Description : AXI4-Lite slave driving a single-port BRAM, one transaction
//               at a time. Optional macro AXI_BRAM_RANGE_CHECK_EN answers
//               out-of-range addresses with SLVERR without touching the BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_bram_ctrl
    import axi_bram_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 18,
    parameter int RD_LATENCY     = 1
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RBI,
    axi_lite_bram_ctrl_if.slave     s_axi,
    output logic                    Bram_Clk_CO,
    output logic                    Bram_Rst_RO,
    output logic                    Bram_En_SO,
    output logic [ADDR_WIDTH-1:0]   Bram_Addr_SO,
    output logic [DATA_WIDTH-1:0]   Bram_Wr_DO,
    output logic [DATA_WIDTH/8-1:0] Bram_WrEn_SO,
    input  logic [DATA_WIDTH-1:0]   Bram_Rd_DI
);
    localparam int                    c_align_bits = align_bits(DATA_WIDTH);
    localparam int                    c_strb_w     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] c_align_mask = {ADDR_WIDTH{1'b1}} << c_align_bits;
    localparam logic [1:0]            c_wait_last  = 2'(RD_LATENCY - 2);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [c_strb_w-1:0]   r_wstrb;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic [1:0]            r_wait_cnt;

    logic w_wr_pend, w_rd_pend;
    logic w_wr_gnt, w_rd_gnt;
    logic w_idle, w_wr_hs, w_rd_hs;
    logic w_wr_oor, w_rd_oor;
    logic w_rd_capture;

    assign Bram_Clk_CO    = Clk_CI;
    assign Bram_Rst_RO    = ~Rst_RBI;
    assign Bram_Addr_SO   = r_addr;
    assign Bram_Wr_DO     = r_wdata;
    assign s_axi.BResp_DO = r_bresp;
    assign s_axi.RResp_DO = r_rresp;
    assign s_axi.RData_DO = r_rdata;

    assign w_wr_pend = s_axi.AwValid_SI & s_axi.WValid_SI;
    assign w_rd_pend = s_axi.ArValid_SI;
    // Readiness is held off while reset is asserted even though the state is IDLE.
    assign w_idle    = (r_state == ST_IDLE) & Rst_RBI;
    assign w_wr_hs   = w_idle & w_wr_gnt;
    assign w_rd_hs   = w_idle & w_rd_gnt;

`ifdef AXI_BRAM_RANGE_CHECK_EN
    assign w_wr_oor = (s_axi.AwAddr_DI >> ADDR_WIDTH) != '0;
    assign w_rd_oor = (s_axi.ArAddr_DI >> ADDR_WIDTH) != '0;
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    axi_bram_rr_arb u_arb (
        .Clk_CI    (Clk_CI),
        .Rst_RBI   (Rst_RBI),
        .i_wr_pend (w_wr_pend),
        .i_rd_pend (w_rd_pend),
        .i_take    (w_wr_hs | w_rd_hs),
        .o_wr_gnt  (w_wr_gnt),
        .o_rd_gnt  (w_rd_gnt)
    );

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rd_capture      = 1'b0;
        s_axi.AwReady_SO  = 1'b0;
        s_axi.WReady_SO   = 1'b0;
        s_axi.ArReady_SO  = 1'b0;
        s_axi.BValid_SO   = 1'b0;
        s_axi.RValid_SO   = 1'b0;
        Bram_En_SO        = 1'b0;
        Bram_WrEn_SO      = '0;
        case (r_state)
            ST_IDLE: begin
                s_axi.AwReady_SO = w_wr_hs;
                s_axi.WReady_SO  = w_wr_hs;
                s_axi.ArReady_SO = w_rd_hs;
                if (w_wr_hs) begin
                    w_state_nxt = w_wr_oor ? ST_WR_RESP : ST_WR_ACC;
                end else if (w_rd_hs) begin
                    w_state_nxt = w_rd_oor ? ST_RD_RESP : ST_RD_ACC;
                end
            end
            ST_WR_ACC: begin
                Bram_En_SO   = 1'b1;
                Bram_WrEn_SO = r_wstrb;
                w_state_nxt  = ST_WR_RESP;
            end
            ST_RD_ACC: begin
                Bram_En_SO = 1'b1;
                if (RD_LATENCY == 1) begin
                    w_state_nxt  = ST_RD_RESP;
                    w_rd_capture = 1'b1;
                end else begin
                    w_state_nxt  = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_state_nxt  = ST_RD_RESP;
                    w_rd_capture = 1'b1;
                end
            end
            ST_WR_RESP: begin
                s_axi.BValid_SO = 1'b1;
                if (s_axi.BReady_SI) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_RESP: begin
                s_axi.RValid_SO = 1'b1;
                if (s_axi.RReady_SI) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rdata    <= '0;
            r_bresp    <= RESP_OKAY;
            r_rresp    <= RESP_OKAY;
            r_wait_cnt <= '0;
        end else begin
            if (w_wr_hs) begin
                r_addr  <= s_axi.AwAddr_DI[ADDR_WIDTH-1:0] & c_align_mask;
                r_wdata <= s_axi.WData_DI;
                r_wstrb <= s_axi.WStrb_DI;
                r_bresp <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (w_rd_hs) begin
                r_addr  <= s_axi.ArAddr_DI[ADDR_WIDTH-1:0] & c_align_mask;
                r_rresp <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
                if (w_rd_oor) begin
                    r_rdata <= '0;
                end
            end
            if (w_rd_capture) begin
                r_rdata <= Bram_Rd_DI;
            end
            if (r_state == ST_RD_ACC) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_RD_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_bram_ctrl
// Description : Directed plus randomized bench for axi_lite_bram_ctrl with a
//               word-array reference memory and a behavioural BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_bram_ctrl;
    localparam int AXW = 32;
    localparam int DW  = 32;
    localparam int BAW = 18;
    localparam int LAT = 1;
`ifdef AXI_BRAM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           bram_clk, bram_rst, bram_en;
    logic [BAW-1:0] bram_addr;
    logic [DW-1:0]  bram_wr, bram_rd;
    logic [3:0]     bram_wren;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_bram_ctrl_if #(.AXI_ADDR_WIDTH(AXW), .DATA_WIDTH(DW)) axi ();

    axi_lite_bram_ctrl #(
        .AXI_ADDR_WIDTH(AXW), .DATA_WIDTH(DW), .ADDR_WIDTH(BAW), .RD_LATENCY(LAT)
    ) dut (
        .Clk_CI       (clk),
        .Rst_RBI      (rst_n),
        .s_axi        (axi),
        .Bram_Clk_CO  (bram_clk),
        .Bram_Rst_RO  (bram_rst),
        .Bram_En_SO   (bram_en),
        .Bram_Addr_SO (bram_addr),
        .Bram_Wr_DO   (bram_wr),
        .Bram_WrEn_SO (bram_wren),
        .Bram_Rd_DI   (bram_rd)
    );

    // Behavioural BRAM: data is presented LAT-1 cycles after the enable cycle,
    // and a poison word is driven whenever the port is not being read.
    logic [31:0] bram [0:65535];
    bit          bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < 65536; i++) bram[i] <= '0;
            bram_init <= 1'b1;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_wren[b]) bram[bram_addr[17:2]][b*8 +: 8] <= bram_wr[b*8 +: 8];
        end
    end
    generate
        if (LAT == 1) begin : g_lat1
            assign bram_rd = bram_en ? bram[bram_addr[17:2]] : 32'hDEAD_0BAD;
        end else begin : g_lat2
            logic [31:0] r_q;
            always @(posedge clk) r_q <= bram_en ? bram[bram_addr[17:2]] : 32'hDEAD_0BAD;
            assign bram_rd = r_q;
        end
    endgenerate

    // Reference: flat word memory, upper address bits alias unless range-checked.
    logic [31:0] ref_mem [int unsigned];

    function automatic bit in_range(input logic [31:0] a);
        return ((a >> BAW) == 0) || !RANGE_EN;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int unsigned idx = int'(a[17:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w = ref_read(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[int'(a[17:2])] = w;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bready_delay);
        bit inr = in_range(a);
        int n = 0;
        axi.AwAddr_DI = a; axi.WData_DI = d; axi.WStrb_DI = s;
        axi.AwValid_SI = 1'b1; axi.WValid_SI = 1'b1;
        #1;
        while (!(axi.AwReady_SO && axi.WReady_SO) && n < 20) begin tick(); n++; end
        check("wr_accept", axi.AwReady_SO && axi.WReady_SO, 1);
        tick();
        axi.AwValid_SI = 1'b0; axi.WValid_SI = 1'b0;
        if (n >= 20) return;
        if (inr) begin
            check("wr_bram_en", bram_en, 1);
            check("wr_bram_wren", bram_wren, s);
            check("wr_bram_addr", bram_addr, a[17:0] & 18'h3FFFC);
            check("wr_bram_data", bram_wr, d);
            check("wr_bvalid_early", axi.BValid_SO, 0);
            tick();
        end else begin
            check("oor_wr_bram_en", bram_en, 0);
        end
        check("wr_bvalid", axi.BValid_SO, 1);
        check("wr_bresp", axi.BResp_DO, inr ? 2'b00 : 2'b10);
        check("wr_bram_idle", bram_en, 0);
        if (bready_delay > 0) begin
            axi.ArAddr_DI = 32'h0; axi.ArValid_SI = 1'b1;
            for (int i = 0; i < bready_delay; i++) begin
                #1;
                check("bp_arready", axi.ArReady_SO, 0);
                tick();
                check("bp_bvalid", axi.BValid_SO, 1);
                check("bp_bresp", axi.BResp_DO, inr ? 2'b00 : 2'b10);
            end
        end
        axi.BReady_SI = 1'b1;
        tick();
        axi.BReady_SI = 1'b0;
        check("wr_bvalid_clear", axi.BValid_SO, 0);
        if (bready_delay > 0) begin
            check("bp_idle_arready", axi.ArReady_SO, 1);
            axi.ArValid_SI = 1'b0;
            #1;
        end
        if (inr) ref_write(a, d, s);
    endtask

    task automatic do_read(input logic [31:0] a, input int rready_delay);
        bit          inr = in_range(a);
        logic [31:0] exp_d = inr ? ref_read(a) : 32'h0;
        int          n = 0;
        axi.ArAddr_DI = a; axi.ArValid_SI = 1'b1;
        #1;
        while (!axi.ArReady_SO && n < 20) begin tick(); n++; end
        check("rd_accept", axi.ArReady_SO, 1);
        tick();
        axi.ArValid_SI = 1'b0;
        if (n >= 20) return;
        if (inr) begin
            check("rd_bram_en", bram_en, 1);
            check("rd_bram_wren", bram_wren, 0);
            check("rd_bram_addr", bram_addr, a[17:0] & 18'h3FFFC);
            for (int k = 0; k < LAT; k++) begin
                check("rd_rvalid_early", axi.RValid_SO, 0);
                tick();
            end
        end else begin
            check("oor_rd_bram_en", bram_en, 0);
        end
        check("rd_rvalid", axi.RValid_SO, 1);
        check("rd_rdata", axi.RData_DO, exp_d);
        check("rd_rresp", axi.RResp_DO, inr ? 2'b00 : 2'b10);
        for (int i = 0; i < rready_delay; i++) begin
            tick();
            check("rd_hold_rvalid", axi.RValid_SO, 1);
            check("rd_hold_rdata", axi.RData_DO, exp_d);
        end
        axi.RReady_SI = 1'b1;
        tick();
        axi.RReady_SI = 1'b0;
        check("rd_rvalid_clear", axi.RValid_SO, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gseq[$];
        int          n;
        logic [31:0] a, d;
        logic [3:0]  s;

        axi.AwAddr_DI = '0; axi.AwValid_SI = 1'b0; axi.WData_DI = '0; axi.WStrb_DI = '0;
        axi.WValid_SI = 1'b0; axi.BReady_SI = 1'b0; axi.ArAddr_DI = '0;
        axi.ArValid_SI = 1'b0; axi.RReady_SI = 1'b0;

        // Reset values, with every request asserted to prove nothing is accepted.
        tick(); tick();
        axi.AwValid_SI = 1'b1; axi.WValid_SI = 1'b1; axi.ArValid_SI = 1'b1;
        #1;
        check("rst_awready", axi.AwReady_SO, 0);
        check("rst_arready", axi.ArReady_SO, 0);
        check("rst_outputs", {axi.BValid_SO, axi.RValid_SO, bram_en, bram_wren}, 0);
        check("rst_data", {axi.RData_DO, axi.BResp_DO, axi.RResp_DO, bram_addr}, 0);
        check("rst_bram_rst", bram_rst, 1);
        axi.AwValid_SI = 1'b0; axi.WValid_SI = 1'b0; axi.ArValid_SI = 1'b0;
        rst_n = 1'b1;
        tick();
        check("bram_rst_release", bram_rst, 0);
        check("bram_clk", bram_clk, clk);

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_read(32'h10, 0);

        do_write(32'h20, 32'h11223344, 4'hF, 0);
        do_write(32'h20, 32'hAABBCCDD, 4'h3, 0);
        do_read(32'h20, 0);
        check("partial_strobe_model", ref_read(32'h20), 32'h1122CCDD);

        do_write(32'h33, 32'h0BADF00D, 4'hF, 0);
        do_read(32'h31, 1);
        do_write(32'h10, 32'h55555555, 4'h0, 0);
        do_read(32'h10, 0);

        do_write(32'h44, 32'hCAFEF00D, 4'hC, 5);
        do_read(32'h44, 3);

        // Half-issued write: AW without W, then W without AW.
        axi.AwAddr_DI = 32'h50; axi.AwValid_SI = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("aw_only_awready", axi.AwReady_SO, 0);
            check("aw_only_wready", axi.WReady_SO, 0);
            tick();
        end
        axi.AwValid_SI = 1'b0; axi.WValid_SI = 1'b1;
        #1;
        check("w_only_wready", axi.WReady_SO, 0);
        tick();
        check("w_only_bram_en", bram_en, 0);
        axi.WValid_SI = 1'b0;

        // Upper address bits: aliasing by default, SLVERR with the range check.
        do_read(32'h0004_0000, 0);
        do_read(32'h0004_0010, 0);
        do_write(32'h0008_0020, 32'h12345678, 4'hF, 0);
        do_read(32'h20, 0);

        // Round-robin under continuous contention, starting from reset.
        apply_reset();
        d = $urandom;
        axi.AwAddr_DI = 32'h60; axi.WData_DI = d; axi.WStrb_DI = 4'hF;
        axi.AwValid_SI = 1'b1; axi.WValid_SI = 1'b1;
        axi.ArAddr_DI = 32'h10; axi.ArValid_SI = 1'b1;
        axi.BReady_SI = 1'b1; axi.RReady_SI = 1'b1;
        #1;
        n = 0;
        while (gseq.size() < 4 && n < 40) begin
            if (axi.ArReady_SO && axi.AwReady_SO) check("arb_dual_grant", 1, 0);
            if (axi.ArReady_SO) gseq.push_back(0);
            else if (axi.AwReady_SO) gseq.push_back(1);
            tick();
            n++;
        end
        axi.AwValid_SI = 1'b0; axi.WValid_SI = 1'b0; axi.ArValid_SI = 1'b0;
        repeat (4) tick();
        axi.BReady_SI = 1'b0; axi.RReady_SI = 1'b0;
        check("arb_grant_count", gseq.size(), 4);
        for (int k = 0; k < gseq.size(); k++) check($sformatf("arb_grant_%0d", k), gseq[k], k % 2);
        ref_mem.delete();
        ref_write(32'h10, 32'hDEADBEEF, 4'hF);
        ref_write(32'h20, 32'h1122CCDD, 4'hF);
        ref_write(32'h30, 32'h0BADF00D, 4'hF);
        ref_write(32'h44, 32'hCAFEF00D, 4'hC);
        if (!RANGE_EN) ref_write(32'h20, 32'h12345678, 4'hF);
        ref_write(32'h60, d, 4'hF);
        do_read(32'h60, 0);

        // Randomized mix against the reference memory.
        for (int t = 0; t < 40; t++) begin
            a = 32'h100 + {$urandom_range(0, 15), 2'b00} + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h0010_0000;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
                do_write(a, d, s, $urandom_range(0, 2));
            end else begin
                do_read(a, $urandom_range(0, 2));
            end
        end

        // Reset during the BRAM read access: everything clears, no response follows.
        axi.ArAddr_DI = 32'h10; axi.ArValid_SI = 1'b1;
        #1;
        n = 0;
        while (!axi.ArReady_SO && n < 20) begin tick(); n++; end
        check("rst_mid_accept", axi.ArReady_SO, 1);
        tick();
        axi.ArValid_SI = 1'b0; axi.RReady_SI = 1'b1;
        check("rst_mid_in_access", bram_en, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {axi.BValid_SO, axi.RValid_SO, bram_en, bram_wren}, 0);
        check("rst_mid_data", {axi.RData_DO, axi.RResp_DO, bram_addr}, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_mid_no_rvalid", axi.RValid_SO, 0);
        end
        axi.RReady_SI = 1'b0;
        do_read(32'h10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
